alu_sched: RTL and testbench
============================

// Module: alu_sched
// PURPOSE
//  Shares the single combinational ALU between NUM_REQ requesters (e.g. PC-increment and execute units).
//  Arbitrates valid/ready requests, drives the ALU from registered operands, captures SUM/EQ, and returns
//  the result to the granted requester over a valid/ready response channel.
//  Sits between the requesting units and the ALU instance; the ALU itself is unchanged.
// PARAMETERS
//  DATA_WIDTH  32  operand/result width; must match the ALU instance
//  NUM_REQ     2   number of requesters (2..8); IDW = $clog2(NUM_REQ)
// PORTS
//  clk        in   1                  clock, all state updates on rising edge
//  rst        in   1                  synchronous reset, active-high
//  req_valid  in   NUM_REQ            per-requester request valid
//  req_ready  out  NUM_REQ            per-requester request accepted (one-hot or zero)
//  req_ctrl   in   NUM_REQ*3          flattened ALU op codes, requester i at [3i+2:3i]
//  req_op1    in   NUM_REQ*DATA_WIDTH flattened operand 1
//  req_op2    in   NUM_REQ*DATA_WIDTH flattened operand 2
//  rsp_valid  out  NUM_REQ            result valid, one-hot to the granted requester
//  rsp_ready  in   NUM_REQ            per-requester result accept
//  rsp_sum    out  DATA_WIDTH         captured ALU result (shared bus)
//  rsp_eq     out  1                  captured ALU equality flag (shared bus)
//  alu_ctrl   out  3                  to ALU op select
//  alu_op1    out  DATA_WIDTH         to ALU operand 1
//  alu_op2    out  DATA_WIDTH         to ALU operand 2
//  alu_sum    in   DATA_WIDTH         from ALU result
//  alu_eq     in   1                  from ALU equality flag
// BEHAVIOUR
//  - FSM states IDLE -> EXEC -> RESP -> IDLE. Reset: state=IDLE, req_ready=0, rsp_valid=0, rsp_sum=0,
//    rsp_eq=0, alu_ctrl/op1/op2=0, grant id=0, priority pointer=0.
//  - IDLE: req_ready is combinational, one-hot on the arbiter winner when any req_valid=1; handshake
//    (valid&ready) latches ctrl/op1/op2 and grant id; next state EXEC. No valid -> stay IDLE, ready=0.
//  - EXEC: alu_* driven from latched registers only; alu_sum/alu_eq captured into rsp_sum/rsp_eq at
//    the end of the cycle; next state RESP. req_ready=0 in EXEC and RESP.
//  - RESP: rsp_valid[gid]=1, rsp_sum/rsp_eq held stable until rsp_ready[gid]=1; then IDLE. rsp_ready
//    bits of non-granted requesters are ignored.
//  - Latency: accept at cycle T -> rsp_valid at T+2; back-to-back throughput 1 op per 3 cycles min.
//  - Op codes pass through unchecked; codes 3'b101..3'b111 yield SUM=0, EQ still computed.
//  - Requester may drop req_valid before acceptance without effect; operands after acceptance ignored.
//  - rsp_valid of a requester never rises in the same cycle as its own req_ready.
//  - Reset mid-operation (EXEC or RESP): pending op discarded, no response ever issued for it.
//  - No arithmetic in this block; widths of alu_sum/rsp_sum identical, no truncation.
// CONFIGURATION
//  ALU_SCHED_RR_EN defined: round-robin; pointer moves to (winner+1) mod NUM_REQ on each accept,
//    search starts at pointer; any continuously-valid requester is granted within NUM_REQ grants.
//  ALU_SCHED_RR_EN undefined: fixed priority, lowest index wins; pointer logic absent.
// STRUCTURE
//  alu_sched_pkg: ALU op localparams (ALU_ADD=3'b000, ALU_SUB=001, ALU_AND=010, ALU_OR=011,
//    ALU_XOR=100), state enum typedef sched_state_t {S_IDLE, S_EXEC, S_RESP}.
//  Sub-module rr_arbiter (NUM_REQ, req vector + pointer in, one-hot grant + index out), combinational;
//    holds both RR and fixed-priority paths under ALU_SCHED_RR_EN.
// TESTING
//  1 Req0 ADD 5+7 alone -> req_ready[0] at T, rsp_valid[0] at T+2, rsp_sum=12, rsp_eq=0.
//  2 Req1 SUB 9-9, rsp_ready[1] held low 4 cycles -> rsp_sum=0, rsp_eq=1 held stable, req_ready=0.
//  3 Both valid continuously, 6 ops -> RR grants 0,1,0,1,0,1; without macro grants 0,0,0,0,0,0.
//  4 Req0 ctrl=3'b111 op1=op2=0xFFFF_FFFF -> rsp_sum=0, rsp_eq=1.
//  5 rst asserted during EXEC of XOR 0xF0^0x0F -> outputs zero next cycle, no rsp_valid ever for it.
//  6 rsp_ready[1]=1 while gid=0 in RESP -> ignored, rsp_valid[0] stays high until rsp_ready[0].

Source files
------------

// File: rtl/alu_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_sched_pkg
// Description : Shared ALU op codes and scheduler state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_sched_pkg;

    // ALU op codes; codes 3'b101..3'b111 are unused and yield SUM=0
    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_XOR = 3'b100;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } sched_state_t;

endpackage
`default_nettype wire

// File: rtl/alu_sched_if.sv
`default_nettype none
// ============================================================================
// Module      : alu_sched_if
// Description : Request/response and ALU-side signal bundle of alu_sched.
//               slave  = scheduler view, master = requesters + ALU view.
// Revision    : 1.0 - initial release
// ============================================================================
interface alu_sched_if #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REQ    = 2
);
    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ-1:0]            req_ready;
    logic [NUM_REQ*3-1:0]          req_ctrl;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_op1;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_op2;
    logic [NUM_REQ-1:0]            rsp_valid;
    logic [NUM_REQ-1:0]            rsp_ready;
    logic [DATA_WIDTH-1:0]         rsp_sum;
    logic                          rsp_eq;
    logic [2:0]                    alu_ctrl;
    logic [DATA_WIDTH-1:0]         alu_op1;
    logic [DATA_WIDTH-1:0]         alu_op2;
    logic [DATA_WIDTH-1:0]         alu_sum;
    logic                          alu_eq;

    modport slave (
        input  req_valid, req_ctrl, req_op1, req_op2, rsp_ready, alu_sum, alu_eq,
        output req_ready, rsp_valid, rsp_sum, rsp_eq, alu_ctrl, alu_op1, alu_op2
    );

    modport master (
        output req_valid, req_ctrl, req_op1, req_op2, rsp_ready, alu_sum, alu_eq,
        input  req_ready, rsp_valid, rsp_sum, rsp_eq, alu_ctrl, alu_op1, alu_op2
    );
endinterface
`default_nettype wire

// File: rtl/alu_sched_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : alu_sched_rr_arbiter
// Description : Combinational request arbiter. With ALU_SCHED_RR_EN defined the
//               search starts at the round-robin pointer; otherwise the lowest
//               requesting index wins and no pointer input exists.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_sched_rr_arbiter #(
    parameter  int NUM_REQ = 2,
    localparam int IDW     = $clog2(NUM_REQ)
) (
    input  wire logic [NUM_REQ-1:0] req,
`ifdef ALU_SCHED_RR_EN
    input  wire logic [IDW-1:0]     ptr,
`endif
    output logic      [NUM_REQ-1:0] grant,
    output logic      [IDW-1:0]     idx
);

    logic w_found;
    int   w_j;

    // First requester found in search order gets the one-hot grant
    always_comb begin
        grant   = '0;
        idx     = '0;
        w_found = 1'b0;
        w_j     = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
`ifdef ALU_SCHED_RR_EN
            w_j = int'(ptr) + i;
            if (w_j >= NUM_REQ) w_j = w_j - NUM_REQ;
`else
            w_j = i;
`endif
            if (!w_found && req[w_j]) begin
                w_found    = 1'b1;
                grant[w_j] = 1'b1;
                idx        = IDW'(w_j);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/alu_sched.sv
`default_nettype none
// ============================================================================
// Module      : alu_sched
// Description : Shares one combinational ALU between NUM_REQ requesters.
//               IDLE -> EXEC -> RESP -> IDLE; operands are latched on accept,
//               the ALU result is captured in EXEC and returned in RESP.
//               Macro ALU_SCHED_RR_EN selects round-robin arbitration
//               (undefined: fixed priority, lowest index wins).
// Revision    : 1.0 - initial release
// ============================================================================
module alu_sched
    import alu_sched_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REQ    = 2
) (
    input  wire logic   clk,
    input  wire logic   rst,
    alu_sched_if.slave  bus
);

    localparam int IDW = $clog2(NUM_REQ);

    sched_state_t          r_state;
    logic [IDW-1:0]        r_gid;
    logic [2:0]            r_ctrl;
    logic [DATA_WIDTH-1:0] r_op1;
    logic [DATA_WIDTH-1:0] r_op2;
    logic [DATA_WIDTH-1:0] r_sum;
    logic                  r_eq;
    logic [NUM_REQ-1:0]    r_rsp_valid;
    logic [NUM_REQ-1:0]    w_grant;
    logic [IDW-1:0]        w_idx;
    logic                  w_accept;

`ifdef ALU_SCHED_RR_EN
    logic [IDW-1:0]        r_ptr;
`endif

    alu_sched_rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .req   (bus.req_valid),
`ifdef ALU_SCHED_RR_EN
        .ptr   (r_ptr),
`endif
        .grant (w_grant),
        .idx   (w_idx)
    );

    // Only IDLE accepts; the grant is only non-zero when some requester is valid
    assign w_accept      = (r_state == S_IDLE) && (w_grant != '0) && !rst;
    assign bus.req_ready = w_accept ? w_grant : '0;

    assign bus.alu_ctrl  = r_ctrl;
    assign bus.alu_op1   = r_op1;
    assign bus.alu_op2   = r_op2;
    assign bus.rsp_sum   = r_sum;
    assign bus.rsp_eq    = r_eq;
    assign bus.rsp_valid = r_rsp_valid;

    // Scheduler FSM: latch request, capture ALU result, hold response until accepted
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_gid       <= '0;
            r_ctrl      <= '0;
            r_op1       <= '0;
            r_op2       <= '0;
            r_sum       <= '0;
            r_eq        <= 1'b0;
            r_rsp_valid <= '0;
`ifdef ALU_SCHED_RR_EN
            r_ptr       <= '0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_ctrl  <= bus.req_ctrl[3*w_idx +: 3];
                        r_op1   <= bus.req_op1[DATA_WIDTH*w_idx +: DATA_WIDTH];
                        r_op2   <= bus.req_op2[DATA_WIDTH*w_idx +: DATA_WIDTH];
                        r_gid   <= w_idx;
`ifdef ALU_SCHED_RR_EN
                        r_ptr   <= (w_idx == IDW'(NUM_REQ-1)) ? '0 : w_idx + IDW'(1);
`endif
                        r_state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    r_sum              <= bus.alu_sum;
                    r_eq               <= bus.alu_eq;
                    r_rsp_valid        <= '0;
                    r_rsp_valid[r_gid] <= 1'b1;
                    r_state            <= S_RESP;
                end
                S_RESP: begin
                    if (bus.rsp_ready[r_gid]) begin
                        r_rsp_valid <= '0;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_rsp_valid <= '0;
                    r_state     <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_alu_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_sched
// Description : Directed self-checking bench for alu_sched with a behavioural
//               ALU attached to the ALU-side signals.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_sched;
    import alu_sched_pkg::*;

    localparam int DW = 32;
    localparam int NR = 2;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_bad;

    alu_sched_if #(.DATA_WIDTH(DW), .NUM_REQ(NR)) bus ();

    alu_sched #(.DATA_WIDTH(DW), .NUM_REQ(NR)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural ALU: unused codes give zero, equality always computed
    logic [DW-1:0] w_alu_sum;
    always_comb begin
        w_alu_sum = '0;
        case (bus.alu_ctrl)
            ALU_ADD: w_alu_sum = bus.alu_op1 + bus.alu_op2;
            ALU_SUB: w_alu_sum = bus.alu_op1 - bus.alu_op2;
            ALU_AND: w_alu_sum = bus.alu_op1 & bus.alu_op2;
            ALU_OR:  w_alu_sum = bus.alu_op1 | bus.alu_op2;
            ALU_XOR: w_alu_sum = bus.alu_op1 ^ bus.alu_op2;
            default: w_alu_sum = '0;
        endcase
    end
    assign bus.alu_sum = w_alu_sum;
    assign bus.alu_eq  = (bus.alu_op1 == bus.alu_op2);

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.req_valid = '0;
        bus.req_ctrl  = '0;
        bus.req_op1   = '0;
        bus.req_op2   = '0;
        bus.rsp_ready = '0;
    endtask

    task automatic apply_reset();
        clear_inputs();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic set_req(input int id, input logic [2:0] ctrl,
                           input logic [DW-1:0] a, input logic [DW-1:0] b);
        bus.req_ctrl[3*id +: 3]  = ctrl;
        bus.req_op1[DW*id +: DW] = a;
        bus.req_op2[DW*id +: DW] = b;
        bus.req_valid[id]        = 1'b1;
    endtask

    // Bounded wait for any req_ready; returns just before the accepting edge
    task automatic wait_grant(output logic [NR-1:0] g, output bit ok);
        ok = 1'b0;
        g  = '0;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (bus.req_ready != '0) begin
                g  = bus.req_ready;
                ok = 1'b1;
                break;
            end
            step();
        end
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if ({bus.req_ready, bus.rsp_valid, bus.rsp_sum, bus.rsp_eq,
             bus.alu_ctrl, bus.alu_op1, bus.alu_op2} !== '0) begin
            n_bad++;
            $display("FAIL reset_outputs: ready=%b vld=%b sum=%h eq=%b ctrl=%b op1=%h op2=%h, required all zero",
                     bus.req_ready, bus.rsp_valid, bus.rsp_sum, bus.rsp_eq,
                     bus.alu_ctrl, bus.alu_op1, bus.alu_op2);
        end
        rst = 1'b0;
    endtask

    task automatic test_add_latency();
        apply_reset();
        set_req(0, ALU_ADD, 32'd5, 32'd7);
        #1;
        n_cmp++;
        if (bus.req_ready !== 2'b01) begin
            n_bad++; $display("FAIL add_ready_T: got %b want 01", bus.req_ready);
        end
        step();
        bus.req_valid = '0;
        bus.req_op1   = '1;
        n_cmp++;
        if (bus.rsp_valid !== 2'b00 || bus.req_ready !== 2'b00) begin
            n_bad++; $display("FAIL add_T1: vld=%b rdy=%b want 00 00", bus.rsp_valid, bus.req_ready);
        end
        step();
        n_cmp++;
        if (bus.rsp_valid !== 2'b01 || bus.rsp_sum !== 32'd12 || bus.rsp_eq !== 1'b0) begin
            n_bad++; $display("FAIL add_T2: vld=%b sum=%0d eq=%b want 01 12 0",
                              bus.rsp_valid, bus.rsp_sum, bus.rsp_eq);
        end
        bus.rsp_ready = 2'b01;
        step();
        bus.rsp_ready = '0;
        n_cmp++;
        if (bus.rsp_valid !== 2'b00) begin
            n_bad++; $display("FAIL add_done: vld=%b want 00", bus.rsp_valid);
        end
    endtask

    task automatic test_sub_hold();
        apply_reset();
        set_req(1, ALU_SUB, 32'd9, 32'd9);
        #1;
        n_cmp++;
        if (bus.req_ready !== 2'b10) begin
            n_bad++; $display("FAIL sub_ready: got %b want 10", bus.req_ready);
        end
        step();
        bus.req_valid = '0;
        step();
        bus.req_valid = 2'b01;
        for (int c = 0; c < 4; c++) begin
            #1;
            n_cmp++;
            if (bus.rsp_valid !== 2'b10 || bus.rsp_sum !== 32'd0 || bus.rsp_eq !== 1'b1 ||
                bus.req_ready !== 2'b00) begin
                n_bad++; $display("FAIL sub_hold[%0d]: vld=%b sum=%0d eq=%b rdy=%b want 10 0 1 00",
                                  c, bus.rsp_valid, bus.rsp_sum, bus.rsp_eq, bus.req_ready);
            end
            step();
        end
        bus.req_valid = '0;
        bus.rsp_ready = 2'b10;
        step();
        bus.rsp_ready = '0;
        n_cmp++;
        if (bus.rsp_valid !== 2'b00) begin
            n_bad++; $display("FAIL sub_done: vld=%b want 00", bus.rsp_valid);
        end
    endtask

    task automatic test_back_to_back();
        logic [NR-1:0] g;
        logic [NR-1:0] exp_g;
        logic [DW-1:0] exp_sum;
        bit            ok;
        apply_reset();
        set_req(0, ALU_ADD, 32'd1,  32'd2);
        set_req(1, ALU_ADD, 32'd10, 32'd20);
        bus.rsp_ready = 2'b11;
        for (int k = 0; k < 6; k++) begin
`ifdef ALU_SCHED_RR_EN
            exp_g = (k % 2 == 0) ? 2'b01 : 2'b10;
`else
            exp_g = 2'b01;
`endif
            exp_sum = (exp_g == 2'b01) ? 32'd3 : 32'd30;
            wait_grant(g, ok);
            n_cmp++;
            if (!ok || g !== exp_g) begin
                n_bad++; $display("FAIL b2b_grant[%0d]: got %b (ok=%0d) want %b", k, g, ok, exp_g);
            end
            step();
            step();
            n_cmp++;
            if (bus.rsp_valid !== exp_g || bus.rsp_sum !== exp_sum) begin
                n_bad++; $display("FAIL b2b_rsp[%0d]: vld=%b sum=%0d want %b %0d",
                                  k, bus.rsp_valid, bus.rsp_sum, exp_g, exp_sum);
            end
            step();
        end
        clear_inputs();
    endtask

    task automatic test_bad_opcode();
        apply_reset();
        set_req(0, 3'b111, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        step();
        bus.req_valid = '0;
        n_cmp++;
        if (bus.alu_ctrl !== 3'b111 || bus.alu_op1 !== 32'hFFFF_FFFF) begin
            n_bad++; $display("FAIL badop_alu: ctrl=%b op1=%h want 111 ffffffff",
                              bus.alu_ctrl, bus.alu_op1);
        end
        step();
        n_cmp++;
        if (bus.rsp_valid !== 2'b01 || bus.rsp_sum !== 32'd0 || bus.rsp_eq !== 1'b1) begin
            n_bad++; $display("FAIL badop_rsp: vld=%b sum=%h eq=%b want 01 0 1",
                              bus.rsp_valid, bus.rsp_sum, bus.rsp_eq);
        end
        bus.rsp_ready = 2'b01;
        step();
        bus.rsp_ready = '0;
    endtask

    task automatic test_reset_mid_exec();
        bit seen;
        apply_reset();
        set_req(0, ALU_XOR, 32'h0000_00F0, 32'h0000_000F);
        step();
        bus.req_valid = '0;
        n_cmp++;
        if (bus.alu_ctrl !== ALU_XOR || bus.alu_op1 !== 32'hF0 || bus.alu_op2 !== 32'h0F) begin
            n_bad++; $display("FAIL rstmid_exec: ctrl=%b op1=%h op2=%h want 100 f0 0f",
                              bus.alu_ctrl, bus.alu_op1, bus.alu_op2);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        n_cmp++;
        if ({bus.rsp_valid, bus.rsp_sum, bus.rsp_eq, bus.alu_ctrl, bus.alu_op1, bus.alu_op2} !== '0) begin
            n_bad++; $display("FAIL rstmid_zero: vld=%b sum=%h eq=%b ctrl=%b op1=%h op2=%h want all zero",
                              bus.rsp_valid, bus.rsp_sum, bus.rsp_eq, bus.alu_ctrl, bus.alu_op1, bus.alu_op2);
        end
        seen = 1'b0;
        for (int c = 0; c < 6; c++) begin
            if (bus.rsp_valid !== 2'b00) seen = 1'b1;
            step();
        end
        n_cmp++;
        if (seen) begin
            n_bad++; $display("FAIL rstmid_norsp: rsp_valid seen=1 want 0");
        end
    endtask

    task automatic test_ignore_other_ready();
        apply_reset();
        set_req(0, ALU_ADD, 32'd3, 32'd4);
        step();
        bus.req_valid = '0;
        step();
        bus.rsp_ready = 2'b10;
        for (int c = 0; c < 3; c++) begin
            #1;
            n_cmp++;
            if (bus.rsp_valid !== 2'b01 || bus.rsp_sum !== 32'd7) begin
                n_bad++; $display("FAIL ignore_rdy[%0d]: vld=%b sum=%0d want 01 7",
                                  c, bus.rsp_valid, bus.rsp_sum);
            end
            step();
        end
        bus.rsp_ready = 2'b01;
        step();
        bus.rsp_ready = '0;
        n_cmp++;
        if (bus.rsp_valid !== 2'b00) begin
            n_bad++; $display("FAIL ignore_done: vld=%b want 00", bus.rsp_valid);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst   = 1'b1;
        clear_inputs();
        test_reset();
        test_add_latency();
        test_sub_hold();
        test_back_to_back();
        test_bad_opcode();
        test_reset_mid_exec();
        test_ignore_other_ready();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
